// File: rtl/timer_pkg.sv
// Shared types and width defaults for the timer interrupt controller.
package timer_pkg;

  localparam int TIMER_CNT_W = 10;
  localparam int TIMER_EVT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } timer_irq_state_e;

endpackage

// File: rtl/tc_edge_detect.sv
// Rising-edge detector for the counter's level terminal_count.
// The history flop resets low, so a level already high at reset release is an edge.
module tc_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tc_in,
  output logic evt_o
);

  logic tc_q, tc_d;

  always_comb tc_d = tc_in;

  always_ff @(posedge clk) begin
    if (!rst_n) tc_q <= 1'b0;
    else        tc_q <= tc_d;
  end

  assign evt_o = tc_in & ~tc_q;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Counts terminal-count events and raises a held interrupt every THRESHOLD events.
// Optional ack-timeout flag enabled by defining TIMER_IRQ_TIMEOUT_EN.
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W       = TIMER_CNT_W,
  parameter int EVT_W       = TIMER_EVT_W,
  parameter int ACK_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tc_in,
  input  logic [CNT_W-1:0] count_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [EVT_W-1:0] cfg_threshold,
  input  logic             cfg_periodic,
  input  logic             cfg_abort,
  output logic             irq_o,
  input  logic             irq_ack_i,
  output logic [EVT_W-1:0] evt_count_o,
  output logic [CNT_W-1:0] snap_o,
  output logic [EVT_W-1:0] missed_o,
  output logic             ovf_o,
  output logic             irq_timeout_o
);

  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  timer_irq_state_e state_q, state_d;
  logic [EVT_W-1:0] thr_q, thr_d;
  logic             periodic_q, periodic_d;
  logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [CNT_W-1:0] snap_q, snap_d;
  logic [EVT_W-1:0] missed_q, missed_d;
  logic             ovf_q, ovf_d;
  logic             evt, cfg_acc, pend_entry;
  logic [EVT_W-1:0] evt_inc;

  tc_edge_detect u_tc_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .tc_in (tc_in),
    .evt_o (evt)
  );

  assign cfg_ready = (state_q == IDLE);
  assign evt_inc   = evt_cnt_q + EVT_ONE;

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    periodic_d = periodic_q;
    evt_cnt_d  = evt_cnt_q;
    snap_d     = snap_q;
    missed_d   = missed_q;
    ovf_d      = ovf_q;
    cfg_acc    = 1'b0;
    pend_entry = 1'b0;
    if (cfg_abort) begin
      state_d   = IDLE;
      evt_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid) begin
          cfg_acc    = 1'b1;
          thr_d      = (cfg_threshold == '0) ? EVT_ONE : cfg_threshold;
          periodic_d = cfg_periodic;
          evt_cnt_d  = '0;
          missed_d   = '0;
          ovf_d      = 1'b0;
          state_d    = ARMED;
        end
        ARMED: if (evt) begin
          if (evt_inc == thr_q) begin
            evt_cnt_d  = thr_q;
            snap_d     = count_in;
            state_d    = PENDING;
            pend_entry = 1'b1;
          end else begin
            evt_cnt_d = evt_inc;
          end
        end
        PENDING: begin
          if (irq_ack_i) begin
            if (!periodic_q) begin
              state_d = IDLE;
            end else if (evt) begin
              // Coincident event opens the next period; with threshold 1 it is a fresh interrupt.
              evt_cnt_d = EVT_ONE;
              if (thr_q == EVT_ONE) begin
                snap_d     = count_in;
                pend_entry = 1'b1;
              end else begin
                state_d = ARMED;
              end
            end else begin
              evt_cnt_d = '0;
              state_d   = ARMED;
            end
          end else if (evt) begin
            if (missed_q != EVT_MAX) missed_d = missed_q + EVT_ONE;
            ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      thr_q      <= EVT_ONE;
      periodic_q <= 1'b0;
      evt_cnt_q  <= '0;
      snap_q     <= '0;
      missed_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      periodic_q <= periodic_d;
      evt_cnt_q  <= evt_cnt_d;
      snap_q     <= snap_d;
      missed_q   <= missed_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TIMER_IRQ_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
  logic            to_flag_q, to_flag_d;

  assign to_inc = to_cnt_q + TO_W'(1);

  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    if (cfg_acc) to_flag_d = 1'b0;
    if (pend_entry) begin
      to_cnt_d = '0;
    end else if (state_q == PENDING && to_cnt_q != TO_MAX) begin
      to_cnt_d = to_inc;
      if (to_inc == TO_MAX) to_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign irq_timeout_o = to_flag_q;
`else
  logic [31:0] unused_ack_timeout;
  logic        unused_cfg_acc;
  assign unused_ack_timeout = 32'(ACK_TIMEOUT);
  assign unused_cfg_acc     = cfg_acc;
  assign irq_timeout_o      = 1'b0;
`endif

  assign irq_o       = (state_q == PENDING);
  assign evt_count_o = evt_cnt_q;
  assign snap_o      = snap_q;
  assign missed_o    = missed_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Downstream consumer of the 10-bit free-running/reloadable timer counter.
- Watches the counter's level-type terminal_count and counts its rising edges.
- After a programmed number of terminal-count events, raises a level interrupt and holds it until acknowledged.
- Snapshots the counter value at interrupt time and flags events missed while the interrupt is pending.
- Supports one-shot and periodic modes.

Parameters:
- CNT_W, 10, width of the counter value input and snapshot.
- EVT_W, 8, width of the event threshold, event counter and missed-event counter.
- ACK_TIMEOUT, 256, cycles in PENDING before timeout is flagged (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- tc_in  in  1  terminal_count from counter; level, high while count is at max.
- count_in  in  CNT_W  live counter value.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when valid&ready.
- cfg_threshold  in  EVT_W  events per interrupt; 0 is treated as 1.
- cfg_periodic  in  1  1 = re-arm after ack; 0 = one-shot.
- cfg_abort  in  1  return to IDLE from any state.
- irq_o  out  1  interrupt level.
- irq_ack_i  in  1  interrupt acknowledge, single-cycle pulse.
- evt_count_o  out  EVT_W  events counted in the current period.
- snap_o  out  CNT_W  count_in captured on the threshold event.
- missed_o  out  EVT_W  events seen while PENDING; saturating.
- ovf_o  out  1  sticky; set on the first missed event.
- irq_timeout_o  out  1  sticky ack timeout (optional feature).

Behaviour:
- Reset: state IDLE; irq_o=0, cfg_ready=1, evt_count_o=0, snap_o=0, missed_o=0, ovf_o=0, irq_timeout_o=0.
- Edge-detect register tc_q is also reset to 0, so tc_in already high at reset release counts as an event.
- Event definition: evt = tc_in & ~tc_q, with tc_q <= tc_in every cycle. A level held for N cycles is one event.
- States: IDLE, ARMED, PENDING. cfg_ready = (state==IDLE); cfg_valid outside IDLE is held off.
- IDLE, on cfg_valid&cfg_ready:
  - latch threshold (0 becomes 1) and periodic;
  - clear evt_count, missed_o, ovf_o, irq_timeout_o;
  - go to ARMED next cycle.
  - Events in IDLE are ignored.
- ARMED, on evt:
  - if evt_count+1 == threshold: evt_count <= threshold, snap_o <= count_in of that cycle, go to PENDING. irq_o rises the cycle after the event (1-cycle latency).
  - else: evt_count <= evt_count+1.
- PENDING:
  - irq_o=1.
  - evt without ack: missed_o increments, saturating at all-ones; ovf_o <= 1.
  - ack, periodic: evt_count <= 0, go to ARMED.
  - ack, one-shot: go to IDLE.
  - irq_o falls the cycle after ack.
- Ack and evt in the same cycle:
  - periodic: the event counts as the first event of the new period, so evt_count <= 1. If threshold==1, stay in PENDING with snap_o updated and irq_o staying high (treated as a new interrupt); otherwise go to ARMED. It is not a missed event.
  - one-shot: go to IDLE; the event is dropped and not counted as missed.
- irq_ack_i outside PENDING: ignored.
- cfg_abort has priority over everything except reset:
  - next cycle: IDLE, irq_o=0, evt_count_o=0;
  - snap_o, missed_o and ovf_o hold their values.
- A cfg_valid in the same cycle as cfg_abort is not accepted.
- Width rules: all counters are unsigned. evt_count never exceeds threshold. missed_o never wraps.
- Reset mid-operation: everything returns to reset values immediately on the next clk edge.

Optional Feature:
- Macro TIMER_IRQ_TIMEOUT_EN.
- Defined:
  - a CNT counter of width $clog2(ACK_TIMEOUT+1) clears on PENDING entry and increments each PENDING cycle;
  - when it reaches ACK_TIMEOUT, irq_timeout_o is set sticky. The interrupt is not withdrawn.
  - irq_timeout_o is cleared on config accept or reset.
- Not defined: irq_timeout_o tied 0, and the counter is not instantiated.

Decomposition:
- Package timer_pkg holds:
  - state enum timer_irq_state_e {IDLE, ARMED, PENDING};
  - localparams TIMER_CNT_W=10 and TIMER_EVT_W=8, used as parameter defaults.
- One sub-module: tc_edge_detect. It holds the tc_q register and rising-edge pulse, with synchronous active-low reset.
- The FSM and counters stay in timer_irq_ctrl.

Test Plan:
- Config threshold=3, one-shot; 3 tc_in pulses, each high 1 cycle, count_in=10'h3FF:
  - irq_o rises 1 cycle after the 3rd edge; snap_o=3FF; evt_count_o=3.
  - ack pulse → irq_o=0 next cycle; state IDLE; cfg_ready=1.
- tc_in held high 5 cycles in ARMED with threshold=2 → evt_count_o=1 and no irq. A second edge → irq.
- Periodic, threshold=2, interrupt pending; 4 further edges before ack → missed_o=4, ovf_o=1. Ack → ARMED, evt_count_o=0. ovf_o stays set until the next cfg accept.
- Periodic, threshold=1, ack and edge in the same cycle → irq_o stays high, snap_o updated, missed_o unchanged.
- cfg_abort during PENDING → irq_o=0 and cfg_ready=1 next cycle. cfg_valid during ARMED → cfg_ready=0 and no latch. cfg_threshold=0 → irq on the first edge.
- With TIMER_IRQ_TIMEOUT_EN, ACK_TIMEOUT=4, no ack → irq_timeout_o=1 after 4 PENDING cycles. Without the macro → irq_timeout_o always 0. Reset asserted mid-PENDING → all outputs at reset values next cycle.
